// File: rtl/bz_flit_serializer_if.sv
// Core-to-serializer word channel: data and valid from the core, ack returned by the serializer.
interface bz_flit_serializer_if #(
  parameter int W = 42
) ();
  logic [W-1:0] d;
  logic         v;
  logic         a;

  modport sink (input d, input v, output a);
  modport source (output d, output v, input a);
endinterface

// File: rtl/bz_flit_serializer.sv
// Splits each core word into a header flit plus N_FLITS data flits for the router FIFO; same-route words share a header up to MAX_BURST.
// Header write follows the accept edge by one cycle, flits stream without bubbles; is_full freezes everything and suppresses ack.
module bz_flit_serializer #(
  parameter int ROUTE_W   = 10,
  parameter int CODE_W    = 8,
  parameter int DATA_W    = 24,
  parameter int PAYLOAD_W = 30,
  parameter int FLIT_W    = 10,
  parameter int MAX_BURST = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  bz_flit_serializer_if.sink     in_channel,
  input  logic                   is_full,
  output logic [FLIT_W:0]        data_out,
  output logic                   wrreq
);
  localparam int IN_W    = ROUTE_W + CODE_W + DATA_W;
  localparam int N_FLITS = PAYLOAD_W / FLIT_W;
  localparam int IDX_W   = (N_FLITS > 1) ? $clog2(N_FLITS) : 1;
  localparam int CNT_W   = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, HDR, DAT} state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [CNT_W-1:0]     burst_cnt;
  logic [ROUTE_W-1:0]   route_q;
  logic [PAYLOAD_W-1:0] pay_q;

  logic [ROUTE_W-1:0]   d_route;
  logic [FLIT_W-1:0]    dat_flit;
  logic                 last;
  logic                 cont;
  logic                 take;
  logic                 unused_d;

  assign d_route  = in_channel.d[IN_W-1 -: ROUTE_W];
  assign unused_d = ^in_channel.d;
  assign last     = (state == DAT) && (idx == IDX_W'(N_FLITS - 1));
  assign cont     = in_channel.v && (d_route == route_q) && (burst_cnt < CNT_W'(MAX_BURST));
  // A word can only be taken when idle or while the last flit is being written.
  assign take     = ((state == IDLE) || last) && in_channel.v && !is_full;
  assign in_channel.a = take && !reset;

  always_comb begin
    dat_flit = '0;
    for (int i = 0; i < N_FLITS; i++) begin
      if (idx == IDX_W'(i)) dat_flit = pay_q[PAYLOAD_W-1-i*FLIT_W -: FLIT_W];
    end
  end

  always_comb begin
    wrreq    = 1'b0;
    data_out = '0;
    case (state)
      HDR: begin
        wrreq    = !is_full;
        data_out = {FLIT_W'(route_q), 1'b0};
      end
      DAT: begin
        wrreq    = !is_full;
        data_out = {dat_flit, last && !cont};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      burst_cnt <= '0;
      route_q   <= '0;
      pay_q     <= '0;
    end else if (!is_full) begin
      case (state)
        IDLE: begin
          if (in_channel.v) begin
            state     <= HDR;
            burst_cnt <= CNT_W'(1);
            route_q   <= d_route;
            pay_q     <= in_channel.d[PAYLOAD_W-1:0];
          end
        end
        HDR: begin
          state <= DAT;
          idx   <= '0;
        end
        DAT: begin
          if (!last) begin
            idx <= idx + IDX_W'(1);
          end else if (cont) begin
            idx       <= '0;
            burst_cnt <= burst_cnt + CNT_W'(1);
            route_q   <= d_route;
            pay_q     <= in_channel.d[PAYLOAD_W-1:0];
          end else if (in_channel.v) begin
            state     <= HDR;
            idx       <= '0;
            burst_cnt <= CNT_W'(1);
            route_q   <= d_route;
            pay_q     <= in_channel.d[PAYLOAD_W-1:0];
          end else begin
            state <= IDLE;
            idx   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bz_flit_serializer.sv
// Directed and randomized bench for bz_flit_serializer; expected FIFO contents come from a word-level model.
module tb_bz_flit_serializer;
  localparam int ROUTE_W   = 10;
  localparam int CODE_W    = 8;
  localparam int DATA_W    = 24;
  localparam int PAYLOAD_W = 30;
  localparam int FLIT_W    = 10;
  localparam int MAX_BURST = 4;
  localparam int IN_W      = ROUTE_W + CODE_W + DATA_W;
  localparam int N_FLITS   = PAYLOAD_W / FLIT_W;

  typedef logic [IN_W-1:0]   word_t;
  typedef logic [FLIT_W:0]   flit_t;

  logic        clk;
  logic        reset;
  logic        is_full;
  flit_t       data_out;
  logic        wrreq;

  bz_flit_serializer_if #(.W(IN_W)) ch ();

  bz_flit_serializer #(
    .ROUTE_W(ROUTE_W), .CODE_W(CODE_W), .DATA_W(DATA_W),
    .PAYLOAD_W(PAYLOAD_W), .FLIT_W(FLIT_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_channel(ch),
    .is_full(is_full),
    .data_out(data_out),
    .wrreq(wrreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_assert = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    wr_cnt   = 0;
  int    a_cnt    = 0;
  int    first_wr = -1;
  int    last_wr  = -1;
  int    full_mode = 0;
  flit_t exp_q[$];
  logic [ROUTE_W-1:0] rt_pool [3] = '{10'h155, 10'h0AA, 10'h001};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic word_t mk(input logic [ROUTE_W-1:0] r, input logic [31:0] cd);
    return {r, cd};
  endfunction

  // Word-level model: a header opens every stream, follows a route change, and follows every MAX_BURST words.
  function automatic void push_group(input word_t ws[$]);
    bit hdr[$];
    int burst = 0;
    for (int k = 0; k < ws.size(); k++) begin
      bit h;
      if (k == 0) h = 1'b1;
      else h = (ws[k][IN_W-1 -: ROUTE_W] != ws[k-1][IN_W-1 -: ROUTE_W]) || (burst == MAX_BURST);
      burst = h ? 1 : burst + 1;
      hdr.push_back(h);
    end
    for (int k = 0; k < ws.size(); k++) begin
      logic [FLIT_W-1:0]    rx;
      logic [PAYLOAD_W-1:0] pl;
      bit                   end_of_word;
      rx = '0;
      rx[ROUTE_W-1:0] = ws[k][IN_W-1 -: ROUTE_W];
      if (hdr[k]) exp_q.push_back({rx, 1'b0});
      end_of_word = (k == ws.size() - 1) ? 1'b1 : hdr[k+1];
      for (int i = 0; i < N_FLITS; i++) begin
        pl = ws[k][PAYLOAD_W-1:0] >> (FLIT_W * (N_FLITS - 1 - i));
        exp_q.push_back({pl[FLIT_W-1:0], (i == N_FLITS - 1) && end_of_word});
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    wr_cnt = 0; a_cnt = 0; first_wr = -1; last_wr = -1;
  endtask

  task automatic send_word(input word_t w);
    bit got = 1'b0;
    ch.d = w;
    ch.v = 1'b1;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (ch.a === 1'b1) got = 1'b1;
    end
    check("accept", got, 1);
    step();
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && exp_q.size() != 0; t++) step();
    check("drain", exp_q.size(), 0);
  endtask

  task automatic run_group(input word_t ws[$]);
    foreach (ws[k]) send_word(ws[k]);
    ch.v = 1'b0;
    drain();
  endtask

  // Scoreboard and protocol monitor, sampling mid-cycle.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (reset === 1'b0) begin
      if (ch.a === 1'b1) a_cnt++;
      if (is_full === 1'b1) begin
        check("stall_wrreq", wrreq, 0);
        check("stall_ack", ch.a, 0);
      end
      if (wrreq === 1'b1) begin
        bit have;
        wr_cnt++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        have = (exp_q.size() != 0);
        check("write_expected", have, 1);
        if (have) check("flit", data_out, exp_q.pop_front());
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (full_mode == 1) is_full = ($urandom_range(0, 3) == 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    word_t g[$];
    word_t w1;
    word_t w2;
    reset = 1'b1; is_full = 1'b0; ch.v = 1'b1; ch.d = '0;
    #3;
    check("rst_ack", ch.a, 0);
    check("rst_wrreq", wrreq, 0);
    check("rst_data", data_out, 0);
    ch.v = 1'b0;
    step();
    reset = 1'b0;
    step();
    check("idle_data", data_out, 0);

    // Single word, literal expectations.
    clear_stats();
    exp_q.push_back(11'h2AA); exp_q.push_back(11'h246);
    exp_q.push_back(11'h22A); exp_q.push_back(11'h4F1);
    g.delete(); g.push_back(mk(10'h155, 32'h12345678));
    run_group(g);
    check("s1_writes", wr_cnt, 4);
    check("s1_span", last_wr - first_wr, 3);
    check("s1_ack_once", a_cnt, 1);
    check("s1_idle_data", data_out, 0);

    // Burst limit.
    clear_stats();
    g.delete();
    for (int k = 0; k < 6; k++) g.push_back(mk(10'h010, $urandom()));
    push_group(g);
    run_group(g);
    check("s2_writes", wr_cnt, 20);
    check("s2_span", last_wr - first_wr, 19);

    // Route change.
    g.delete();
    g.push_back(mk(10'h001, $urandom()));
    g.push_back(mk(10'h001, $urandom()));
    g.push_back(mk(10'h002, $urandom()));
    push_group(g);
    run_group(g);

    // Backpressure on data flit 1.
    exp_q.push_back(11'h2AA); exp_q.push_back(11'h246);
    exp_q.push_back(11'h22A); exp_q.push_back(11'h4F1);
    send_word(mk(10'h155, 32'h12345678));
    ch.v = 1'b0;
    step(); step();
    is_full = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("s4_hold_wrreq", wrreq, 0);
      check("s4_hold_data", data_out, 11'h22A);
      step();
    end
    is_full = 1'b0;
    drain();

    // Full at the last flit, next word waiting.
    w1 = mk(10'h0AA, $urandom());
    w2 = mk(10'h0AA, $urandom());
    g.delete(); g.push_back(w1); g.push_back(w2);
    push_group(g);
    send_word(w1);
    ch.d = w2;
    step(); step(); step();
    is_full = 1'b1;
    @(negedge clk); check("s5_stall_ack0", ch.a, 0);
    step();
    @(negedge clk); check("s5_stall_ack1", ch.a, 0);
    step();
    is_full = 1'b0;
    @(negedge clk); check("s5_accept", ch.a, 1);
    step();
    ch.v = 1'b0;
    drain();

    // Same, but valid drops during the stall.
    g.delete(); g.push_back(w1);
    push_group(g);
    send_word(w1);
    ch.d = w2;
    step(); step(); step();
    is_full = 1'b1;
    @(negedge clk); check("s5b_stall_ack", ch.a, 0);
    step();
    ch.v = 1'b0;
    @(negedge clk); check("s5b_drop_ack", ch.a, 0);
    step();
    is_full = 1'b0;
    drain();

    // Reset during data flit 1.
    w1 = mk(10'h155, $urandom());
    g.delete(); g.push_back(w1);
    push_group(g);
    send_word(w1);
    step(); step();
    #2;
    exp_q.delete();
    reset = 1'b1;
    #1;
    check("s6_wrreq", wrreq, 0);
    check("s6_ack", ch.a, 0);
    check("s6_data", data_out, 0);
    push_group(g);
    step();
    reset = 1'b0;
    run_group(g);

    // Randomized streams under random backpressure.
    full_mode = 1;
    for (int n = 0; n < 25; n++) begin
      int len = $urandom_range(1, 6);
      g.delete();
      for (int k = 0; k < len; k++) g.push_back(mk(rt_pool[$urandom_range(0, 2)], $urandom()));
      push_group(g);
      run_group(g);
      repeat ($urandom_range(0, 2)) step();
    end
    full_mode = 0;
    is_full = 1'b0;
    step();
    check("final_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/bz_flit_serializer.md
# bz_flit_serializer

Parametrised successor to the fixed 3-flit core-to-router serializer. It converts each core output word into one header flit plus `N_FLITS` data flits and writes them into the router's input FIFO. Consecutive words with the same route share one header. A configurable burst limit forces a fresh header after `MAX_BURST` words so the router does not hold one path indefinitely. The block sits between the core's output `Channel` and the router input FIFO write port.

## Interface
- `ROUTE_W`, 10: route field width, in the MSBs of the input word; must be ≤ `FLIT_W`.
- `CODE_W`, 8: code field width.
- `DATA_W`, 24: data field width.
- `PAYLOAD_W`, 30: LSBs of the input word that are serialized; must be a multiple of `FLIT_W`.
- `FLIT_W`, 10: payload bits per flit. Each flit is `FLIT_W+1` bits: `{payload, tail}`.
- `MAX_BURST`, 16: maximum words per header, ≥1. A value of 1 gives one header per word.
- Derived: `IN_W = ROUTE_W+CODE_W+DATA_W`, `N_FLITS = PAYLOAD_W/FLIT_W`.

Ports:
- `clk`  in  1  the only clock.
- `reset`  in  1  asynchronous, active-high.
- `in_channel`  Channel  `IN_W`  core words. Fields: `d` (data), `v` (valid), `a` (ack, driven here).
- `is_full`  in  1  target FIFO is full.
- `data_out`  out  `FLIT_W+1`  flit to write.
- `wrreq`  out  1  FIFO write strobe.

## Operation
- Transfer rule: a word transfers on a rising edge where `v & a`. On that edge the block captures `route_q = d[IN_W-1 -: ROUTE_W]` and `pay_q = d[PAYLOAD_W-1:0]`.
- Header flit: `{zero-extend(route_q) to FLIT_W, 1'b0}`.
- Data flit i, for i = 0..N_FLITS-1, MS-first: `{pay_q[PAYLOAD_W-1-i*FLIT_W -: FLIT_W], tail}`. `tail` is 0 except as defined for the last flit.
- States: `IDLE`, `HDR`, `DAT` (with flit index `idx`), and the last-flit decision when `DAT` and `idx == N_FLITS-1`.
- `IDLE`:
  - `a = v & !is_full`, `wrreq = 0`.
  - On a transfer, go to `HDR`; `burst_cnt <= 1`.
- `HDR`:
  - `wrreq = !is_full`, `data_out` = header flit, `a = 0`.
  - If `!is_full`, go to `DAT` with `idx = 0`; otherwise hold.
- `DAT`, not last flit:
  - `wrreq = !is_full`, `a = 0`.
  - If `!is_full`, `idx++`; otherwise hold.
- `DAT`, last flit:
  - `wrreq = !is_full`, `a = v & !is_full`.
  - `cont = v & (d route == route_q) & (burst_cnt < MAX_BURST)`; `tail = !cont`.
  - If `is_full`, hold.
  - Else if `cont`, capture the new word, go to `DAT` with `idx = 0`, `burst_cnt++`.
  - Else if `v`, capture the new word, go to `HDR`, `burst_cnt <= 1`.
  - Else go to `IDLE`.
- Stall rule: whenever `is_full`, state, `idx`, `route_q`, `pay_q` and `data_out` hold and `wrreq = 0`. No flit is dropped or duplicated.
- Simultaneity: `is_full` high in the last-flit cycle also suppresses `a`. The capture and the tail decision are re-evaluated in the next non-full cycle.
- Header compression applies only within a continuous stream. A word accepted from `IDLE` always gets a header.
- `burst_cnt` width is `$clog2(MAX_BURST+1)`. It never exceeds `MAX_BURST`.

## Timing
- Reset (async): state = `IDLE`, `idx = 0`, `burst_cnt = 0`, `route_q = 0`, `pay_q = 0`. Outputs: `wrreq = 0`, `data_out = 0`, `a = 0`.
- `a` is forced 0 while `reset` is high.
- Reset mid-packet: the partial packet is abandoned (no tail is emitted). The first word after release gets a header.
- `data_out = 0` in `IDLE`.
- `a` and `wrreq` are combinational from state, `v` and `is_full`. `data_out` is a mux of registered state, plus the `d`-route compare for the tail bit.
- Latency: the header `wrreq` is asserted in the cycle after the accept edge. No bubble between flits without backpressure.
- Throughput: `N_FLITS+1` cycles for a header word, `N_FLITS` cycles for a continued word.

## Test plan
Defaults except `MAX_BURST = 4`. Word = `{route, code, payload[29:0]}`.

1. **Single word.** Route `0x155`, payload `0x12345678`, then `v` low → four consecutive writes: `0x2AA`, `0x246`, `0x22A`, `0x4F1` (tail = 1), then `IDLE`. `a` high exactly once, in the `IDLE` cycle.
2. **Burst limit.** 6 back-to-back words, all route `0x010` → 20 writes in 20 cycles. Headers precede words 1 and 5. The last flit of words 1–3 and 5 has tail = 0; the last flit of words 4 and 6 has tail = 1.
3. **Route change.** Routes `0x001`, `0x001`, `0x002` back to back → flits H, D×3 (tail 0), D×3 (tail 1), H(`0x004`), D×3 (tail 1).
4. **Backpressure.** `is_full` high for 3 cycles while data flit 1 is presented → `wrreq = 0` and `data_out` stable for 3 cycles, then resume. FIFO contents are identical to scenario 1.
5. **Full at last flit.** `is_full` high in the last-flit cycle while the next word is valid → `a = 0` that cycle, and the word is accepted in the first non-full cycle. In a second run, `v` drops during the stall → tail = 1.
6. **Reset mid-packet.** Assert async `reset` during data flit 1 → `wrreq`, `a` and `data_out` go to 0 immediately. After release, a same-route word starts with a header flit.
